// File: rtl/avalon_burst_reader_pkg.sv
// Shared definitions for the Avalon-MM burst reader: FSM encoding and the
// byteenable fill constant.
package avalon_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Wide enough for any DATA_W up to 1024 bits; users slice the low DATA_W/8 bits.
  localparam int unsigned          BE_MAX_W    = 128;
  localparam logic [BE_MAX_W-1:0]  BE_ALL_ONES = '1;

endpackage

// File: rtl/avalon_burst_reader_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry.
// Writes while full (without a simultaneous read) and reads while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned        PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd = rd_en && (r_count != '0);
  assign w_wr = wr_en && ((r_count != FULL_CNT) || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign count   = r_count;

endmodule

// File: rtl/avalon_burst_reader.sv
// Avalon-MM burst reader: issues word_count sequential reads from start_addr,
// limited by a credit of DEPTH (in flight + buffered), and streams the returns out.
module avalon_burst_reader
  import avalon_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    word_count,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned       BE_W      = DATA_W / 8;
  localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BE_W);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [BE_W-1:0]   BE_ONES   = BE_ALL_ONES[BE_W-1:0];

  state_t            r_state;
  logic              r_read;
  logic              r_busy;
  logic              r_done;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_outstanding;

  logic              w_issue;
  logic              w_ret;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W-1:0]  w_out_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LEN_W-1:0]  w_rem_nxt;
  logic              w_read_nxt;

  // avm_read is registered, so the credit test looks ahead at next-cycle
  // outstanding/occupancy; a stalled request is always held regardless of credit.
  always_comb begin
    w_issue    = r_read && !avm_waitrequest;
    w_ret      = avm_readdatavalid && (r_outstanding != '0) &&
                 ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    w_pop      = out_ready && !w_empty;
    w_out_nxt  = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_ret);
    w_cnt_nxt  = w_fifo_count + CNT_W'(w_ret) - CNT_W'(w_pop);
    w_rem_nxt  = r_remaining - LEN_W'(w_issue);
    w_read_nxt = (r_state == ST_ISSUE) &&
                 ((r_read && avm_waitrequest) ||
                  ((w_rem_nxt != '0) && !w_full &&
                   (({1'b0, w_out_nxt} + {1'b0, w_cnt_nxt}) < DEPTH_C)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_read        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_be          <= '0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_done        <= 1'b0;
      r_read        <= w_read_nxt;
      r_be          <= w_read_nxt ? BE_ONES : '0;
      if (w_issue) begin
        r_addr      <= r_addr + ADDR_STEP;
        r_remaining <= w_rem_nxt;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (word_count != '0) begin
              r_state     <= ST_ISSUE;
              r_addr      <= start_addr;
              r_remaining <= word_count;
              r_read      <= 1'b1;
              r_be        <= BE_ONES;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue && (r_remaining == LEN_W'(1))) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((r_outstanding == '0) && w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_ret_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_ret),
    .wr_data (avm_readdata),
    .rd_en   (w_pop),
    .rd_data (out_data),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_fifo_count)
  );

  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_byteenable = r_be;
  assign out_valid      = !w_empty;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: doc/avalon_burst_reader.md
AVALON_BURST_READER -- requirements
Module: avalon_burst_reader

Interface
REQ-001 Parameter DATA_W, default 32, read data width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter LEN_W, default 8, width of word_count.
REQ-004 Parameter DEPTH, default 4, max reads in flight plus buffered words (power of two, >=2).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a transfer; ignored unless IDLE.
REQ-008 start_addr  input  ADDR_W  byte address of first word, sampled on accepted start.
REQ-009 word_count  input  LEN_W  number of words, sampled on accepted start; 0 means no reads.
REQ-010 avm_address  output  ADDR_W  Avalon-MM read address.
REQ-011 avm_read  output  1  Avalon-MM read request.
REQ-012 avm_byteenable  output  DATA_W/8  all ones whenever avm_read=1.
REQ-013 avm_waitrequest  input  1  slave stall; request held while high.
REQ-014 avm_readdatavalid  input  1  one returned word this cycle.
REQ-015 avm_readdata  input  DATA_W  returned word.
REQ-016 out_data  output  DATA_W  head word of return buffer.
REQ-017 out_valid  output  1  out_data valid.
REQ-018 out_ready  input  1  consumer accepts word when out_valid&out_ready.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-021 States SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-022 IDLE->ISSUE on start with word_count>0; IDLE->DONE on start with word_count=0.
REQ-023 In ISSUE avm_read SHALL be 1 only when credit = outstanding + buffered < DEPTH.
REQ-024 A read is issued on a cycle with avm_read=1 and avm_waitrequest=0; address then advances by DATA_W/8, remaining count decrements.
REQ-025 While avm_waitrequest=1, avm_address, avm_read, avm_byteenable SHALL hold stable.
REQ-026 Once asserted, avm_read SHALL NOT drop until the read is issued, even if credit changes.
REQ-027 ISSUE->DRAIN in the cycle the last read is issued.
REQ-028 Every avm_readdatavalid word SHALL be written into the buffer in order; overflow is impossible by REQ-023.
REQ-029 out_valid SHALL be 1 whenever the buffer is non-empty; out_data is the oldest word.
REQ-030 Simultaneous return and consume: outstanding and occupancy update consistently in one cycle; word passes with no bubble.
REQ-031 Simultaneous issue and return in one cycle: outstanding unchanged.
REQ-032 DRAIN->DONE when outstanding=0 and buffer empty; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-033 Latency: first avm_read no later than the cycle after start accepted; returned word visible on out_valid the cycle after avm_readdatavalid.
REQ-034 Sustained throughput with waitrequest=0, out_ready=1, readdatavalid latency L < DEPTH: one word per cycle.
REQ-035 Address wraps modulo 2^ADDR_W; no error raised.

Reset
REQ-036 reset_n low SHALL force IDLE, avm_read=0, avm_address=0, avm_byteenable=0, out_valid=0, busy=0, done=0, counters and buffer empty, immediately and independent of clk.
REQ-037 Reset mid-transfer SHALL abandon the transfer; late readdatavalid after reset release while IDLE SHALL be discarded.

Structure
REQ-038 State encoding and the byteenable-all-ones constant SHALL live in a shared package.
REQ-039 The return buffer SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; ports clk, reset_n, wr_en, wr_data, rd_en, rd_data, empty, full, count).

Verification
REQ-040 Reset: assert reset_n=0 mid-ISSUE -> avm_read=0, busy=0 same cycle; no done pulse.
REQ-041 start, addr=0x100, count=4, waitrequest=0, L=2, out_ready=1 -> addresses 0x100,0x104,0x108,0x10C in 4 consecutive cycles; 4 words out in order; done once.
REQ-042 waitrequest high 3 cycles on second read -> address 0x104 and avm_read held stable 3 cycles; total 4 reads issued.
REQ-043 out_ready=0 throughout, count=8, DEPTH=4 -> exactly 4 reads issued then avm_read=0; after out_ready=1, remaining 4 issued; 8 words delivered.
REQ-044 start with count=0 -> no avm_read; done pulse one cycle after start; back to IDLE.
REQ-045 start while busy, addr=0xFFFFFFFC count=2 -> second start ignored; second address 0x00000000.
